moving_average_filter_p: RTL and testbench

Parametrised successor to the team's fixed moving-average FIR filter. Computes a 2^LOG2_DEPTH-tap boxcar average of a signed sample stream using a running-sum accumulator and a circular delay line, with a valid handshake, synchronous flush and selectable rounding. Sits directly after the sample source (ADC/RAM playback) and feeds downstream DSP or analog-waveform monitors in simulation.

---
 rtl/moving_average_filter_p.sv | 86 ++++++++
 tb/tb_moving_average_filter_p.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/moving_average_filter_p.sv
// Boxcar moving average over 2^LOG2_DEPTH signed samples.
// Uses a running-sum accumulator and a circular delay line, with one cycle of latency.
module moving_average_filter_p #(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 3,
  parameter int ROUND      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int PW    = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int AW    = DATA_W + LOG2_DEPTH;
  localparam int FW    = LOG2_DEPTH + 1;
  localparam int BIAS  = (ROUND != 0 && LOG2_DEPTH > 0) ?
                         (1 << ((LOG2_DEPTH > 0) ? LOG2_DEPTH - 1 : 0)) : 0;

  logic signed [DATA_W-1:0] r_mem [DEPTH];
  logic        [PW-1:0]     r_wp;
  logic signed [AW-1:0]     r_acc;
  logic        [FW-1:0]     r_fc;
  logic signed [DATA_W-1:0] r_data_p1;
  logic                     r_vld_p1;
  logic                     r_primed_p1;

  logic signed [AW-1:0]     w_acc_next;
  logic        [PW-1:0]     w_wp_next;
  logic        [FW-1:0]     w_fc_next;

  // Divide by DEPTH via arithmetic shift; one guard bit keeps the biased sum exact.
  function automatic logic signed [DATA_W-1:0] avg_round(input logic signed [AW-1:0] a);
    logic signed [AW:0] b;
    b = $signed({a[AW-1], a}) + $signed((AW+1)'(BIAS));
    b = b >>> LOG2_DEPTH;
    return b[DATA_W-1:0];
  endfunction

  always_comb begin
    w_acc_next = r_acc + AW'(data_in) - AW'(r_mem[r_wp]);
    w_wp_next  = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
    w_fc_next  = (r_fc == FW'(DEPTH)) ? r_fc : r_fc + 1'b1;
  end

  // stage p0 -> p1: window update and registered average
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp        <= '0;
      r_acc       <= '0;
      r_fc        <= '0;
      r_data_p1   <= '0;
      r_vld_p1    <= 1'b0;
      r_primed_p1 <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp        <= '0;
      r_acc       <= '0;
      r_fc        <= '0;
      r_data_p1   <= '0;
      r_vld_p1    <= 1'b0;
      r_primed_p1 <= 1'b0;
    end else if (in_valid) begin
      r_mem[r_wp] <= data_in;
      r_wp        <= w_wp_next;
      r_acc       <= w_acc_next;
      r_fc        <= w_fc_next;
      r_data_p1   <= avg_round(w_acc_next);
      r_vld_p1    <= 1'b1;
      r_primed_p1 <= (w_fc_next == FW'(DEPTH));
    end else begin
      r_vld_p1    <= 1'b0;
    end
  end

  assign out_valid = r_vld_p1;
  assign data_out  = r_data_p1;
  assign primed    = r_primed_p1;

endmodule

// File: tb/tb_moving_average_filter_p.sv
// Directed bench for moving_average_filter_p (depth 8), truncating and rounding instances.
// Expected results are queued at stimulus time and popped by a monitor on out_valid.
module tb_moving_average_filter_p;

  logic clk = 1'b0;
  logic reset, clear, in_valid;
  logic signed [15:0] data_in;
  logic ov0, ov1, pr0, pr1;
  logic signed [15:0] d0, d1;

  moving_average_filter_p #(.DATA_W(16), .LOG2_DEPTH(3), .ROUND(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .out_valid(ov0), .data_out(d0), .primed(pr0));

  moving_average_filter_p #(.DATA_W(16), .LOG2_DEPTH(3), .ROUND(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .out_valid(ov1), .data_out(d1), .primed(pr1));

  always #5 clk = ~clk;

  typedef struct {int d0; int d1; bit pr;} exp_t;
  exp_t q[$];
  int   hist[$];
  int   nacc;
  int   errors = 0;
  int   checks = 0;
  int   epoch  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  task automatic model_clear();
    hist.delete();
    nacc = 0;
  endtask

  task automatic model_push(input int v);
    exp_t e;
    int   s;
    hist.push_back(v);
    if (hist.size() > 8) void'(hist.pop_front());
    s = 0;
    foreach (hist[i]) s += hist[i];
    nacc++;
    e.d0 = floor_div(s, 8);
    e.d1 = floor_div(s + 4, 8);
    e.pr = (nacc >= 8);
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    data_in  = 16'(v);
    model_push(v);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_clear(input bit iv, input int v);
    clear    = 1'b1;
    in_valid = iv;
    data_in  = 16'(v);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    epoch++;
  endtask

  task automatic hand(input string name, input int e0, input int e1);
    check({name, "_d0"}, int'(d0), e0);
    check({name, "_d1"}, int'(d1), e1);
  endtask

  // Monitor: pops on every output pulse, otherwise verifies the held value.
  int  hold0 = 0, hold1 = 0, seen_epoch = 0;
  bit  hold_pr = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (epoch != seen_epoch) begin
        hold0 = 0; hold1 = 0; hold_pr = 1'b0; seen_epoch = epoch;
      end
      check("ov_agree", int'(ov1), int'(ov0));
      if (ov0) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_d0", int'(d0), e.d0);
          check("sb_d1", int'(d1), e.d1);
          check("sb_primed0", int'(pr0), int'(e.pr));
          check("sb_primed1", int'(pr1), int'(e.pr));
          hold0 = e.d0; hold1 = e.d1; hold_pr = e.pr;
        end
      end else begin
        check("hold_d0", int'(d0), hold0);
        check("hold_d1", int'(d1), hold1);
        check("hold_primed", int'(pr0), int'(hold_pr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b1; data_in = 16'sd1234;
    model_clear();
    // Reset held with a valid input present
    repeat (5) begin
      tick();
      check("rst_ov", int'(ov0 | ov1), 0);
      check("rst_d", int'(d0) | int'(d1), 0);
      check("rst_primed", int'(pr0 | pr1), 0);
    end
    reset = 1'b0;
    epoch++;
    send(1234);
    hand("first", 154, 154);
    check("first_primed", int'(pr0), 0);
    idle(2);

    // Step response
    do_clear(1'b0, 0);
    send(0);
    hand("step0", 0, 0);
    for (int k = 1; k <= 9; k++) begin
      send(80);
      v = (k < 8) ? 10 * k : 80;
      hand("step", v, v);
      if (k == 6) check("step_primed_lo", int'(pr0), 0);
      if (k == 7) check("step_primed_hi", int'(pr0), 1);
    end
    idle(3);

    // Sine, period 32, amplitude 100
    do_clear(1'b0, 0);
    for (int n = 0; n < 48; n++)
      send(int'(100.0 * $sin(2.0 * 3.14159265358979 * n / 32.0)));
    idle(2);

    // Single -1 then zeros
    do_clear(1'b0, 0);
    send(-1);
    hand("neg1", -1, 0);
    for (int k = 1; k <= 8; k++) begin
      send(0);
      if (k == 7) hand("neg1_tail", -1, 0);
      if (k == 8) hand("neg1_gone", 0, 0);
    end
    idle(1);

    // Rounding with +4
    do_clear(1'b0, 0);
    send(4);
    hand("plus4", 0, 1);
    repeat (8) send(4);
    hand("plus4_full", 4, 4);
    idle(1);

    // Full scale both polarities
    do_clear(1'b0, 0);
    send(32767);
    hand("fs_first", 4095, 4096);
    repeat (7) send(32767);
    hand("fs_pos", 32767, 32767);
    repeat (8) send(-32768);
    hand("fs_neg", -32768, -32768);
    idle(2);

    // Gapped handshake
    do_clear(1'b0, 0);
    for (int k = 1; k <= 8; k++) begin
      send(8 * k);
      if ($urandom_range(0, 1) != 0) idle(1 + $urandom_range(0, 2));
    end
    idle(1);
    hand("gap_final", 36, 36);
    check("gap_primed", int'(pr0), 1);
    idle(2);

    // Clear with an accompanying sample
    do_clear(1'b1, 800);
    hand("clr", 0, 0);
    check("clr_primed", int'(pr0), 0);
    check("clr_ov", int'(ov0), 0);
    send(800);
    hand("after_clr", 100, 100);
    idle(1);

    // Asynchronous reset pulse between edges
    #2 reset = 1'b1;
    #1;
    check("async_rst_d", int'(d0) | int'(d1), 0);
    check("async_rst_primed", int'(pr0 | pr1), 0);
    reset = 1'b0;
    model_clear();
    epoch++;
    tick();
    send(40);
    hand("post_rst", 5, 5);
    idle(3);

    check("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
